// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, field positions and the decoded-head payload type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned JADDR_MSB  = 25;
  localparam int unsigned JADDR_LSB  = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jump_address;
    logic        is_rtype;
    logic        is_jump;
    logic        is_branch;
  } decode_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational MIPS field extraction and classification; all zero when the word is not valid.
module instr_decode
  import mips_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  logic [5:0] op;

  assign op = instr_i[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    dec_o = '0;
    if (valid_i) begin
      dec_o.opcode       = op;
      dec_o.rs           = instr_i[RS_MSB:RS_LSB];
      dec_o.rt           = instr_i[RT_MSB:RT_LSB];
      dec_o.rd           = instr_i[RD_MSB:RD_LSB];
      dec_o.shamt        = instr_i[SHAMT_MSB:SHAMT_LSB];
      dec_o.funct        = instr_i[FUNCT_MSB:FUNCT_LSB];
      dec_o.immediate    = instr_i[IMM_MSB:IMM_LSB];
      dec_o.jump_address = instr_i[JADDR_MSB:JADDR_LSB];
      dec_o.is_rtype     = (op == OP_RTYPE);
      dec_o.is_jump      = (op == OP_J) || (op == OP_JAL);
      dec_o.is_branch    = (op == OP_BEQ) || (op == OP_BNE);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry instruction FIFO of {instr, pc} pairs with a decoded view of the head entry.
module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            in_instr,
  input  logic [PCW-1:0]           in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PCW-1:0]           out_pc,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              immediate,
  output logic [25:0]              jump_address,
  output logic                     is_rtype,
  output logic                     is_jump,
  output logic                     is_branch,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0]  instr_mem_q [DEPTH];
  logic [PCW-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [IW-1:0] head_instr;
  decode_t       dec;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flush wins over any push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign out_pc     = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  instr_decode u_decode (
    .valid_i (out_valid),
    .instr_i (head_instr[31:0]),
    .dec_o   (dec)
  );

  assign opcode       = dec.opcode;
  assign rs           = dec.rs;
  assign rt           = dec.rt;
  assign rd           = dec.rd;
  assign shamt        = dec.shamt;
  assign funct        = dec.funct;
  assign immediate    = dec.immediate;
  assign jump_address = dec.jump_address;
  assign is_rtype     = dec.is_rtype;
  assign is_jump      = dec.is_jump;
  assign is_branch    = dec.is_branch;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: decode vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   immediate;
  logic [25:0]   jump_address;
  logic          is_rtype, is_jump, is_branch;
  logic [CW-1:0] count;

  instr_fetch_queue #(.DEPTH(DEPTH), .IW(32), .PCW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .funct        (funct),
    .immediate    (immediate),
    .jump_address (jump_address),
    .is_rtype     (is_rtype),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] ja;
    logic        r;
    logic        j;
    logic        b;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] mq [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the model queue head with shift/mask arithmetic.
  task automatic check_all();
    logic [31:0] w;
    logic [31:0] p;
    logic        v;
    int unsigned op;
    v = (mq.size() != 0);
    w = 32'h0;
    p = 32'h0;
    if (v) begin
      w = mq[0][63:32];
      p = mq[0][31:0];
    end
    op = (w >> 26) & 32'h3F;
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_pc", 64'(out_pc), 64'(p));
    chk("opcode", 64'(opcode), 64'(op));
    chk("rs", 64'(rs), 64'((w >> 21) & 32'h1F));
    chk("rt", 64'(rt), 64'((w >> 16) & 32'h1F));
    chk("rd", 64'(rd), 64'((w >> 11) & 32'h1F));
    chk("shamt", 64'(shamt), 64'((w >> 6) & 32'h1F));
    chk("funct", 64'(funct), 64'(w & 32'h3F));
    chk("immediate", 64'(immediate), 64'(w & 32'hFFFF));
    chk("jump_address", 64'(jump_address), 64'(w & 32'h03FF_FFFF));
    chk("is_rtype", 64'(is_rtype), 64'(v && op == 0));
    chk("is_jump", 64'(is_jump), 64'(v && (op == 2 || op == 3)));
    chk("is_branch", 64'(is_branch), 64'(v && (op == 4 || op == 5)));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    do_push   = iv && (mq.size() != DEPTH);
    do_pop    = ordy && (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({ins, p});
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vecs[0] = '{32'h0030_0020, 32'h0000_0000, 6'd0, 5'd1, 5'd16, 5'd0, 5'd0, 6'h20, 16'h0020, 26'h030_0020, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h1000_0030, 32'h0000_0004, 6'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h30, 16'h0030, 26'h000_0030, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h0800_1234, 32'h0000_0008, 6'd2, 5'd0, 5'd0, 5'd2, 5'd8, 6'h34, 16'h1234, 26'h000_1234, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0C00_0001, 32'h0000_000C, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h01, 16'h0001, 26'h000_0001, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h1422_FFFF, 32'h0000_0010, 6'd5, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h022_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h8C00_0000, 32'h0000_0014, 6'd35, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h000_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h03E0_0008, 32'h0000_0018, 6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0008, 26'h3E0_0008, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;

    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table: push one word, check the decoded head, pop it.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].instr, vecs[i].pc, 1'b0, 1'b0);
      chk("vec_valid", 64'(out_valid), 64'(1));
      chk("vec_pc", 64'(out_pc), 64'(vecs[i].pc));
      chk("vec_opcode", 64'(opcode), 64'(vecs[i].op));
      chk("vec_rs", 64'(rs), 64'(vecs[i].rs));
      chk("vec_rt", 64'(rt), 64'(vecs[i].rt));
      chk("vec_rd", 64'(rd), 64'(vecs[i].rd));
      chk("vec_shamt", 64'(shamt), 64'(vecs[i].sh));
      chk("vec_funct", 64'(funct), 64'(vecs[i].fn));
      chk("vec_imm", 64'(immediate), 64'(vecs[i].imm));
      chk("vec_jaddr", 64'(jump_address), 64'(vecs[i].ja));
      chk("vec_rtype", 64'(is_rtype), 64'(vecs[i].r));
      chk("vec_jump", 64'(is_jump), 64'(vecs[i].j));
      chk("vec_branch", 64'(is_branch), 64'(vecs[i].b));
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("vec_stall_opcode", 64'(opcode), 64'(vecs[i].op));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("vec_drained", 64'(out_valid), 64'(0));
    end

    // Fill to full, refuse a fifth word, drain in order.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h2000_0000 + 32'(k), 32'(k * 4), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_in_ready", 64'(in_ready), 64'(0));
    step(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("fifth_rejected", 64'(count), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(out_pc), 64'(k * 4));
      chk("drain_valid", 64'(out_valid), 64'(1));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(out_valid), 64'(0));
    chk("drain_count", 64'(count), 64'(0));

    // Full with push and pop together: push is refused, count drops.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h0800_0000 + 32'(k), 32'h40 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_0000, 32'h99, 1'b1, 1'b0);
    chk("full_pushpop_count", 64'(count), 64'(3));
    chk("full_pushpop_head", 64'(out_pc), 64'(32'h41));

    // Flush with count=3 and a word offered: nothing survives.
    step(1'b1, 32'h1111_1111, 32'h77, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_not_stored", 64'(count), 64'(0));

    // Concurrent push/pop at count=2 long enough to wrap both pointers.
    step(1'b1, 32'h0000_0100, 32'd100, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0101, 32'd101, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 32'h0000_0102 + 32'(j), 32'd102 + 32'(j), 1'b1, 1'b0);
      chk("conc_count", 64'(count), 64'(2));
      chk("conc_order", 64'(out_pc), 64'(100 + j + 1));
    end

    // Async reset pulse between edges with entries queued.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_reset_count", 64'(count), 64'(2));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    chk("async_rst_pc", 64'(out_pc), 64'(0));
    chk("async_rst_opcode", 64'(opcode), 64'(0));
    mq.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all();
    step(1'b1, 32'h1000_0030, 32'h500, 1'b0, 1'b0);
    chk("post_reset_push", 64'(count), 64'(1));

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] w;
      case ($urandom_range(0, 5))
        0: op = 6'd0;
        1: op = 6'd2;
        2: op = 6'd3;
        3: op = 6'd4;
        4: op = 6'd5;
        default: op = 6'($urandom);
      endcase
      w = {op, 26'($urandom)};
      step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
